// File: rtl/pwm_ramp_sequencer_if.sv
// Config handshake between system control logic and pwm_ramp_sequencer.
interface pwm_ramp_sequencer_if #(
    parameter int unsigned WIDTH = 5
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_target;
    logic [WIDTH-1:0] cfg_step;

    modport master (output cfg_valid, output cfg_target, output cfg_step, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_target, input  cfg_step, output cfg_ready);
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Ramps a PWM generator's duty toward a configured target, stepping only at period boundaries.
// Optional watchdog fault state is compiled in with `define PWM_SEQ_WATCHDOG_EN.
module pwm_ramp_sequencer #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    pwm_ramp_sequencer_if.slave cfg,
    input  logic             start,
    input  logic             stop,
    input  logic             period_done,
    output logic             pwm_enable,
    output logic [WIDTH-1:0] duty,
    output logic             busy,
    output logic             at_target,
    output logic             fault
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD,
        S_STOPPING
`ifdef PWM_SEQ_WATCHDOG_EN
        , S_FAULT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [7:0]       pcnt_q, pcnt_d;

    logic             accept;
    logic             cfg_ready_w;
    logic [WIDTH-1:0] goal;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH-1:0] stepped;

    assign cfg_ready_w   = ((state_q == S_IDLE) || (state_q == S_HOLD)) && !stop;
    assign cfg.cfg_ready = cfg_ready_w;
    assign accept        = cfg.cfg_valid && cfg_ready_w;

    assign pwm_enable = (state_q == S_RAMP) || (state_q == S_HOLD) || (state_q == S_STOPPING);
    assign busy       = (state_q == S_RAMP) || (state_q == S_STOPPING);
    assign at_target  = (state_q == S_HOLD);
    assign duty       = duty_q;

    // Extra carry/borrow bit lets the clamp catch overshoot without wrapping.
    assign goal    = (state_q == S_STOPPING) ? '0 : target_q;
    assign up_sum  = {1'b0, duty_q} + {1'b0, step_q};
    assign dn_diff = {1'b0, duty_q} - {1'b0, step_q};
    always_comb begin
        stepped = goal;
        if (duty_q < goal) begin
            if (up_sum < {1'b0, goal}) stepped = up_sum[WIDTH-1:0];
        end else if (duty_q > goal) begin
            if (!dn_diff[WIDTH] && (dn_diff > {1'b0, goal})) stepped = dn_diff[WIDTH-1:0];
        end
    end

    assign eff_target = accept ? cfg.cfg_target : target_q;

`ifdef PWM_SEQ_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           wdog_trip;

    always_comb begin
        wdog_d    = '0;
        wdog_trip = 1'b0;
        if (pwm_enable && !period_done) begin
            wdog_d    = wdog_q + 1'b1;
            wdog_trip = (wdog_q == WDW'(WDOG_CYCLES - 1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end

    assign fault = (state_q == S_FAULT);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        pcnt_d   = pcnt_q;

        if (accept) begin
            target_d = cfg.cfg_target;
            step_d   = (cfg.cfg_step == '0) ? WIDTH'(1) : cfg.cfg_step;
        end

        case (state_q)
            S_IDLE: begin
                duty_d = '0;
                if (start) begin
                    pcnt_d  = '0;
                    state_d = (eff_target == '0) ? S_HOLD : S_RAMP;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = (duty_q == '0) ? S_IDLE : S_STOPPING;
                end else if (accept && (cfg.cfg_target != duty_q)) begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP, S_STOPPING: begin
                if (period_done) begin
                    if (pcnt_q == 8'(STEP_DIV - 1)) begin
                        duty_d = stepped;
                        pcnt_d = '0;
                        if (stepped == goal)
                            state_d = (state_q == S_STOPPING) ? S_IDLE : S_HOLD;
                    end else begin
                        pcnt_d = pcnt_q + 8'd1;
                    end
                end
                if ((state_q == S_RAMP) && stop) begin
                    state_d = (duty_q == '0) ? S_IDLE : S_STOPPING;
                    if (duty_q == '0) duty_d = '0;
                end
            end
            default: begin
                duty_d = '0;
            end
        endcase

`ifdef PWM_SEQ_WATCHDOG_EN
        if (wdog_trip) begin
            state_d = S_FAULT;
            duty_d  = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= WIDTH'(1);
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            pcnt_q   <= pcnt_d;
        end
    end
endmodule
